// File: rtl/gfx_wbm_rw_arbiter_n.sv
// N-master Wishbone read/write arbiter: round-robin or fixed priority, registered one-hot grant,
// a hold limit that forces re-arbitration when other masters are waiting.
module gfx_wbm_rw_arbiter_n #(
  parameter int unsigned MDW      = 256,
  parameter int unsigned NM       = 6,
  parameter int unsigned RR       = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NM-1:0]         m_read_request_i,
  input  logic [NM-1:0]         m_write_request_i,
  input  logic [NM*32-1:0]      m_addr_i,
  input  logic [NM-1:0]         m_we_i,
  input  logic [NM*MDW/8-1:0]   m_sel_i,
  input  logic [NM*MDW-1:0]     m_dat_i,
  output logic [MDW-1:0]        m_dat_o,
  output logic [NM-1:0]         m_ack_o,
  output logic [NM-1:0]         grant_o,
  output logic                  master_busy_o,
  output logic                  read_request_o,
  output logic                  write_request_o,
  output logic [31:0]           addr_o,
  output logic                  we_o,
  output logic [MDW/8-1:0]      sel_o,
  output logic [MDW-1:0]        dat_o,
  input  logic [MDW-1:0]        dat_i,
  input  logic                  ack_i
);

  localparam int unsigned SW = MDW / 8;
  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e        state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    hold_q, hold_d;

  logic [NM-1:0] req;
  logic [IW-1:0] win_idx, cand;
  logic          win_found, others, req_g, hold_full;

  assign req           = m_read_request_i | m_write_request_i;
  assign master_busy_o = |req;
  assign others        = |(req & ~grant_q);
  assign req_g         = |(req & grant_q);
  assign hold_full     = (hold_q == 8'(MAX_HOLD - 1));

  // Winner search; round-robin starts just after the last released master.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    if (RR != 0) begin
      for (int unsigned i = 1; i <= NM; i++) begin
        cand = IW'((32'(last_q) + i) % NM);
        if (!win_found && req[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NM; i++) begin
        if (req[IW'(i)]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          grant_d = NM'(1) << win_idx;
          gidx_d  = win_idx;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (!req_g || (ack_i && hold_full && others)) begin
          state_d = StIdle;
          grant_d = '0;
          last_d  = gidx_q;
          hold_d  = '0;
        end else if (ack_i && !hold_full) begin
          // Saturates at MAX_HOLD-1 so the next ack releases once someone else waits.
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NM - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    read_request_o  = 1'b0;
    write_request_o = 1'b0;
    we_o            = 1'b0;
    addr_o          = '0;
    sel_o           = '0;
    dat_o           = '0;
    if (state_q == StGrant) begin
      read_request_o  = m_read_request_i[gidx_q];
      write_request_o = m_write_request_i[gidx_q] & ~m_read_request_i[gidx_q];
      we_o            = m_we_i[gidx_q];
      addr_o          = m_addr_i[32*gidx_q +: 32];
      sel_o           = m_sel_i[SW*gidx_q +: SW];
      dat_o           = m_dat_i[MDW*gidx_q +: MDW];
    end
  end

  assign grant_o = grant_q;
  assign m_ack_o = grant_q & {NM{ack_i}};
  assign m_dat_o = dat_i;

endmodule

// File: tb/tb_gfx_wbm_rw_arbiter_n.sv
// Bench for gfx_wbm_rw_arbiter_n: three configurations share one stimulus stream and are
// checked by directed tables/sequences and by a random run against an ownership model.
module tb_gfx_wbm_rw_arbiter_n;
  localparam int NM  = 6;
  localparam int MDW = 32;
  localparam int SW  = MDW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0] rd, wr, we;
  logic [NM*32-1:0] addr;
  logic [NM*SW-1:0] sel;
  logic [NM*MDW-1:0] dat;
  logic [MDW-1:0] sdat;
  logic ack;

  logic [MDW-1:0] o_mdat[3];
  logic [NM-1:0]  o_mack[3];
  logic [NM-1:0]  o_grant[3];
  logic           o_busy[3];
  logic           o_rreq[3];
  logic           o_wreq[3];
  logic [31:0]    o_addr[3];
  logic           o_we[3];
  logic [SW-1:0]  o_sel[3];
  logic [MDW-1:0] o_dat[3];

  always #5 clk = ~clk;

  // d0: RR, hold 8   d1: RR, hold 1   d2: fixed priority, hold 8
  gfx_wbm_rw_arbiter_n #(.MDW(MDW), .NM(NM), .RR(1), .MAX_HOLD(8)) u_d0 (
    .clk_i(clk), .rst_i(rst), .m_read_request_i(rd), .m_write_request_i(wr),
    .m_addr_i(addr), .m_we_i(we), .m_sel_i(sel), .m_dat_i(dat), .m_dat_o(o_mdat[0]),
    .m_ack_o(o_mack[0]), .grant_o(o_grant[0]), .master_busy_o(o_busy[0]),
    .read_request_o(o_rreq[0]), .write_request_o(o_wreq[0]), .addr_o(o_addr[0]),
    .we_o(o_we[0]), .sel_o(o_sel[0]), .dat_o(o_dat[0]), .dat_i(sdat), .ack_i(ack)
  );
  gfx_wbm_rw_arbiter_n #(.MDW(MDW), .NM(NM), .RR(1), .MAX_HOLD(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .m_read_request_i(rd), .m_write_request_i(wr),
    .m_addr_i(addr), .m_we_i(we), .m_sel_i(sel), .m_dat_i(dat), .m_dat_o(o_mdat[1]),
    .m_ack_o(o_mack[1]), .grant_o(o_grant[1]), .master_busy_o(o_busy[1]),
    .read_request_o(o_rreq[1]), .write_request_o(o_wreq[1]), .addr_o(o_addr[1]),
    .we_o(o_we[1]), .sel_o(o_sel[1]), .dat_o(o_dat[1]), .dat_i(sdat), .ack_i(ack)
  );
  gfx_wbm_rw_arbiter_n #(.MDW(MDW), .NM(NM), .RR(0), .MAX_HOLD(8)) u_d2 (
    .clk_i(clk), .rst_i(rst), .m_read_request_i(rd), .m_write_request_i(wr),
    .m_addr_i(addr), .m_we_i(we), .m_sel_i(sel), .m_dat_i(dat), .m_dat_o(o_mdat[2]),
    .m_ack_o(o_mack[2]), .grant_o(o_grant[2]), .master_busy_o(o_busy[2]),
    .read_request_o(o_rreq[2]), .write_request_o(o_wreq[2]), .addr_o(o_addr[2]),
    .we_o(o_we[2]), .sel_o(o_sel[2]), .dat_o(o_dat[2]), .dat_i(sdat), .ack_i(ack)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus (-1 = nobody), who last owned it, acks in this tenure.
  int owner[3] = '{-1, -1, -1};
  int last[3]  = '{NM - 1, NM - 1, NM - 1};
  int cnt[3]   = '{0, 0, 0};
  int rrc[3]   = '{1, 1, 0};
  int mhc[3]   = '{8, 1, 8};

  typedef struct {
    logic          rst;
    logic [NM-1:0] rd;
    logic [NM-1:0] wr;
    logic          ack;
    logic [NM-1:0] e_grant;
    logic          e_rreq;
    logic          e_wreq;
    logic [NM-1:0] e_mack;
    logic [31:0]   e_addr;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(int d);
    int r = -1;
    logic [NM-1:0] q = rd | wr;
    if (rrc[d] != 0) begin
      for (int i = 1; i <= NM; i++) begin
        int idx = (last[d] + i) % NM;
        if (r < 0 && q[idx]) r = idx;
      end
    end else begin
      for (int i = 0; i < NM; i++) if (q[i]) r = i;
    end
    return r;
  endfunction

  task automatic step_models();
    logic [NM-1:0] q;
    q = rd | wr;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        owner[d] = -1; last[d] = NM - 1; cnt[d] = 0;
      end else if (owner[d] < 0) begin
        int p = pick(d);
        if (p >= 0) begin owner[d] = p; cnt[d] = 0; end
      end else begin
        logic [NM-1:0] oth = q;
        oth[owner[d]] = 1'b0;
        if (!q[owner[d]] || (ack && cnt[d] == mhc[d] - 1 && |oth)) begin
          last[d] = owner[d]; owner[d] = -1;
        end else if (ack && cnt[d] < mhc[d] - 1) begin
          cnt[d]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    step_models();
    #1;
  endtask

  task automatic check_dut(int d);
    logic [NM-1:0] eg, em;
    logic er, ew, ewe;
    logic [31:0] ea;
    logic [SW-1:0] es;
    logic [MDW-1:0] ed;
    eg = '0; er = 0; ew = 0; ewe = 0; ea = '0; es = '0; ed = '0;
    if (owner[d] >= 0) begin
      int o = owner[d];
      eg[o] = 1'b1;
      er  = rd[o];
      ew  = wr[o] & ~rd[o];
      ewe = we[o];
      ea  = addr[o*32 +: 32];
      es  = sel[o*SW +: SW];
      ed  = dat[o*MDW +: MDW];
    end
    em = ack ? eg : '0;
    chk($sformatf("d%0d grant", d), 64'(o_grant[d]), 64'(eg));
    chk($sformatf("d%0d mack", d), 64'(o_mack[d]), 64'(em));
    chk($sformatf("d%0d rreq", d), 64'(o_rreq[d]), 64'(er));
    chk($sformatf("d%0d wreq", d), 64'(o_wreq[d]), 64'(ew));
    chk($sformatf("d%0d we", d), 64'(o_we[d]), 64'(ewe));
    chk($sformatf("d%0d addr", d), 64'(o_addr[d]), 64'(ea));
    chk($sformatf("d%0d sel", d), 64'(o_sel[d]), 64'(es));
    chk($sformatf("d%0d dat", d), 64'(o_dat[d]), 64'(ed));
    chk($sformatf("d%0d mdat", d), 64'(o_mdat[d]), 64'(sdat));
    chk($sformatf("d%0d busy", d), 64'(o_busy[d]), 64'(|(rd | wr)));
  endtask

  logic [NM-1:0] seq_b[7];

  initial begin
    // Record i: inputs applied after edge i; expectations reflect state after edge i.
    tbl[0]  = '{1'b0, 6'b000100, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 32'h0};
    tbl[1]  = '{1'b0, 6'b000100, 6'b000000, 1'b0, 6'b000100, 1'b1, 1'b0, 6'b000000, 32'hA0000002};
    tbl[2]  = '{1'b0, 6'b000100, 6'b000000, 1'b1, 6'b000100, 1'b1, 1'b0, 6'b000100, 32'hA0000002};
    tbl[3]  = '{1'b0, 6'b000000, 6'b000000, 1'b1, 6'b000100, 1'b0, 1'b0, 6'b000100, 32'hA0000002};
    tbl[4]  = '{1'b0, 6'b000000, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 32'h0};
    tbl[5]  = '{1'b0, 6'b000000, 6'b001000, 1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 32'h0};
    tbl[6]  = '{1'b0, 6'b000001, 6'b001000, 1'b0, 6'b001000, 1'b0, 1'b1, 6'b000000, 32'hA0000003};
    tbl[7]  = '{1'b1, 6'b000001, 6'b001000, 1'b0, 6'b001000, 1'b0, 1'b1, 6'b000000, 32'hA0000003};
    tbl[8]  = '{1'b0, 6'b000001, 6'b001000, 1'b1, 6'b000000, 1'b0, 1'b0, 6'b000000, 32'h0};
    tbl[9]  = '{1'b0, 6'b000001, 6'b001000, 1'b0, 6'b000001, 1'b1, 1'b0, 6'b000000, 32'hA0000000};
    tbl[10] = '{1'b0, 6'b000000, 6'b000000, 1'b0, 6'b000001, 1'b0, 1'b0, 6'b000000, 32'hA0000000};
    tbl[11] = '{1'b0, 6'b000000, 6'b000000, 1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 32'h0};

    seq_b = '{6'b000001, 6'b000000, 6'b001000, 6'b000000, 6'b100000, 6'b000000, 6'b000001};

    rst = 1'b1; rd = '0; wr = '0; ack = 1'b0; we = '1; sdat = 32'h5A5A_0F0F;
    sel = '1; dat = '0;
    for (int k = 0; k < NM; k++) addr[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    tick();
    tick();

    // Directed table on d0.
    for (int i = 0; i < 12; i++) begin
      tick();
      rst = tbl[i].rst; rd = tbl[i].rd; wr = tbl[i].wr; ack = tbl[i].ack;
      @(negedge clk);
      chk($sformatf("tbl%0d grant", i), 64'(o_grant[0]), 64'(tbl[i].e_grant));
      chk($sformatf("tbl%0d rreq", i), 64'(o_rreq[0]), 64'(tbl[i].e_rreq));
      chk($sformatf("tbl%0d wreq", i), 64'(o_wreq[0]), 64'(tbl[i].e_wreq));
      chk($sformatf("tbl%0d mack", i), 64'(o_mack[0]), 64'(tbl[i].e_mack));
      chk($sformatf("tbl%0d addr", i), 64'(o_addr[0]), 64'(tbl[i].e_addr));
    end

    // Round-robin with hold 1 on d1: masters 0, 3, 5 always requesting and always acked.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; rd = 6'b101001; wr = '0; ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("rr seq%0d", i), 64'(o_grant[1]), 64'(seq_b[i]));
    end

    // Fixed priority on d2: master 4 beats master 1 until it drops.
    tick(); rst = 1'b1; ack = 1'b0; rd = '0;
    tick(); rst = 1'b0; rd = 6'b010010;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("fixed hold%0d", i), 64'(o_grant[2]), 64'(6'b010000));
    end
    tick(); rd = 6'b000010;
    @(negedge clk); chk("fixed drop", 64'(o_grant[2]), 64'(6'b010000));
    tick(); @(negedge clk); chk("fixed bubble", 64'(o_grant[2]), 64'(6'b000000));
    tick(); @(negedge clk); chk("fixed next", 64'(o_grant[2]), 64'(6'b000010));

    // Hold limit on d0: master 1 released after 8 acks while master 0 waits.
    tick(); rst = 1'b1; rd = '0;
    tick(); rst = 1'b0; rd = 6'b000010;
    tick(); @(negedge clk); chk("hold grant1", 64'(o_grant[0]), 64'(6'b000010));
    tick(); rd = 6'b000011; ack = 1'b1;
    @(negedge clk); chk("hold mack", 64'(o_mack[0]), 64'(6'b000010));
    for (int k = 1; k < 8; k++) begin
      tick(); @(negedge clk);
      chk($sformatf("hold ack%0d", k), 64'(o_grant[0]), 64'(6'b000010));
    end
    tick(); ack = 1'b0;
    @(negedge clk); chk("hold release", 64'(o_grant[0]), 64'(6'b000000));
    tick(); @(negedge clk); chk("hold next0", 64'(o_grant[0]), 64'(6'b000001));

    // Without a waiter the grant survives 20 acks.
    tick(); rst = 1'b1; rd = '0;
    tick(); rst = 1'b0; rd = 6'b000010;
    tick(); ack = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    @(negedge clk); chk("hold sat", 64'(o_grant[0]), 64'(6'b000010));
    ack = 1'b0; rd = '0;

    // Random run against the model on all three configurations.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int k = 0; k < NM; k++) begin
        if (rd[k]) rd[k] = ($urandom_range(0, 5) != 0);
        else       rd[k] = ($urandom_range(0, 3) == 0);
        if (wr[k]) wr[k] = ($urandom_range(0, 5) != 0);
        else       wr[k] = ($urandom_range(0, 5) == 0);
        addr[k*32 +: 32] = $urandom;
        dat[k*MDW +: MDW] = $urandom;
        sel[k*SW +: SW] = SW'($urandom);
        we[k] = 1'($urandom);
      end
      ack  = 1'($urandom);
      sdat = $urandom;
      rst  = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      for (int d = 0; d < 3; d++) check_dut(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
